// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
// LOADER_CHECKSUM_EN adds the S_CSUM state to the encoding.
package program_loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;
`endif

  // True in every state that still consumes bytes from the host link.
  function automatic logic state_accepts(state_t s);
    return (s != S_DONE) && (s != S_ERR);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream plus program-memory write port and loader status.
// The slave modport is the loader; the master modport is the host/SoC side.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Shifts stream bytes into a little-endian 32-bit word; word_complete marks the 4th byte.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_complete
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  // Newest byte enters at the top so the first byte ends up in [7:0].
  assign word_next     = {byte_in, word_q[31:8]};
  assign word_complete = byte_valid && (idx_q == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (byte_valid) begin
      word_d = word_next;
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte image into program memory and holds the CPU until done.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  program_loader_if.slave        bus
);

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           wcount_q, wcount_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        hs;
  logic        data_hs;
  logic [15:0] n_len;
  logic [15:0] wcount_inc;
  logic [31:0] word_next;
  logic        word_complete;

  assign hs         = bus.rx_valid && rx_ready_q;
  assign data_hs    = hs && (state_q == S_DATA);
  assign n_len      = {bus.rx_data, len_q[7:0]};
  assign wcount_inc = wcount_q + 16'd1;

  word_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .byte_valid    (data_hs),
    .byte_in       (bus.rx_data),
    .word_next     (word_next),
    .word_complete (word_complete)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wcount_d    = wcount_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = done_q;
    error_d     = error_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    if (hs && (state_q != S_CSUM))
      csum_d = csum_q ^ bus.rx_data;
`endif

    case (state_q)
      S_LEN0: begin
        if (hs) begin
          len_d[7:0] = bus.rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (hs) begin
          len_d = n_len;
          if (n_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d    = S_CSUM;
`else
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
`endif
          end else if (int'(n_len) > MAX_WORDS) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_complete) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wcount_q[ADDR_WIDTH-1:0];
          mem_wdata_d = word_next;
          wcount_d    = wcount_inc;
          if (wcount_inc == len_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d    = S_CSUM;
`else
            // Release lands in the same cycle as the final write strobe.
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (hs) begin
          if (bus.rx_data == csum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: ;
    endcase

    rx_ready_d = state_accepts(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LEN0;
      len_q       <= '0;
      wcount_q    <= '0;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wcount_q    <= wcount_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

endmodule
